// File: rtl/swi_conditioner.sv
// Synchronise, debounce and edge-detect the SWI switch bank on clk_2.
// Define SWI_AUTOREPEAT_EN to add per-bit auto-repeat rise pulses.
module swi_conditioner #(
    parameter int NBITS         = 8,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [NBITS-1:0] SWI,
    output logic [NBITS-1:0] swi_db,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic             any_rise,
    output logic [7:0]       press_cnt
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic [NBITS-1:0] r_sync1;
    logic [NBITS-1:0] r_sync2;
    logic [NBITS-1:0] r_db;
    logic [NBITS-1:0] r_rise;
    logic [NBITS-1:0] r_fall;
    logic             r_any;
    logic [7:0]       r_press;
    logic [CW-1:0]    r_cnt [NBITS];

    logic [NBITS-1:0] w_chg;
    logic [NBITS-1:0] w_rep;
    logic [NBITS-1:0] w_rise;
    logic [NBITS-1:0] w_fall;

    // A bit flips only after DEB_CYCLES consecutive mismatching samples.
    always_comb begin
        w_chg = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_chg[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == CMAX);
        end
    end

    assign w_rise = (w_chg & r_sync2) | w_rep;
    assign w_fall = w_chg & ~r_sync2;

`ifdef SWI_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rcnt [NBITS];

    // A bit that is falling this cycle must not also repeat.
    always_comb begin
        w_rep = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_rep[i] = r_db[i] && !w_chg[i] && (r_rcnt[i] == RMAX);
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBITS; i++) begin
                r_rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (!r_db[i] || w_rise[i]) begin
                    r_rcnt[i] <= '0;
                end else begin
                    r_rcnt[i] <= r_rcnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign w_rep = '0;
`endif

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= SWI;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (r_sync2[i] == r_db[i] || w_chg[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            r_db   <= (r_db & ~w_chg) | (r_sync2 & w_chg);
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_any  <= |w_rise;
        end
    end

    // Counts registered bit-0 rise pulses, hence one cycle behind them.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_press <= '0;
        end else begin
            r_press <= r_press + {7'd0, r_rise[0]};
        end
    end

    assign swi_db    = r_db;
    assign swi_rise  = r_rise;
    assign swi_fall  = r_fall;
    assign any_rise  = r_any;
    assign press_cnt = r_press;

endmodule

// File: tb/tb_swi_conditioner.sv
// Randomised and directed bench for swi_conditioner against a
// sample-window reference model.
module tb_swi_conditioner;

    localparam int NB  = 8;
    localparam int DEB = 4;
    localparam int REP = 16;

    logic          clk_2 = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] SWI = '0;
    logic [NB-1:0] swi_db;
    logic [NB-1:0] swi_rise;
    logic [NB-1:0] swi_fall;
    logic          any_rise;
    logic [7:0]    press_cnt;

    int n_chk = 0;
    int n_err = 0;
    int n_rise2 = 0;
    int n_fall0 = 0;

    swi_conditioner #(
        .NBITS(NB),
        .DEB_CYCLES(DEB),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk_2(clk_2),
        .reset_n(reset_n),
        .SWI(SWI),
        .swi_db(swi_db),
        .swi_rise(swi_rise),
        .swi_fall(swi_fall),
        .any_rise(any_rise),
        .press_cnt(press_cnt)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model: history of synchronised samples per edge.
    logic [NB-1:0] m_s1 = '0;
    logic [NB-1:0] m_s2 = '0;
    logic [NB-1:0] m_db = '0;
    logic [NB-1:0] m_rise = '0;
    logic [NB-1:0] m_fall = '0;
    logic          m_any = 1'b0;
    logic [7:0]    m_pc = '0;
    logic [NB-1:0] shist[$];
    int            since[NB];
    int            lastr[NB];
    int            m_edge = 0;
    logic [NB-1:0] ndb, nr, nf;
    bit            ok;

    always @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            m_rise = '0; m_fall = '0; m_any = 1'b0;
            m_pc = '0; m_edge = 0;
            shist.delete();
            for (int i = 0; i < NB; i++) begin
                since[i] = 0;
                lastr[i] = -100000;
            end
        end else begin
            shist.push_back(m_s2);
            if (shist.size() > 64) void'(shist.pop_front());
            ndb = m_db; nr = '0; nf = '0;
            for (int i = 0; i < NB; i++) begin
                since[i]++;
                ok = (since[i] >= DEB);
                for (int k = 1; k <= DEB && ok; k++) begin
                    if (shist[shist.size() - k][i] == m_db[i]) ok = 0;
                end
                if (ok) begin
                    ndb[i] = m_s2[i];
                    since[i] = 0;
                    if (m_s2[i]) nr[i] = 1'b1;
                    else nf[i] = 1'b1;
                end
`ifdef SWI_AUTOREPEAT_EN
                else if (m_db[i] && (m_edge - lastr[i] == REP)) begin
                    nr[i] = 1'b1;
                end
`endif
                if (nr[i]) lastr[i] = m_edge;
            end
            m_pc = m_pc + 8'(m_rise[0]);
            m_db = ndb; m_rise = nr; m_fall = nf;
            m_any = |nr;
            m_s2 = m_s1; m_s1 = SWI;
            m_edge++;
        end
    end

    always @(negedge clk_2) begin
        if (reset_n) begin
            chk("db", 32'(swi_db), 32'(m_db));
            chk("rise", 32'(swi_rise), 32'(m_rise));
            chk("fall", 32'(swi_fall), 32'(m_fall));
            chk("any", 32'(any_rise), 32'(m_any));
            chk("pcnt", 32'(press_cnt), 32'(m_pc));
            chk("excl", 32'(swi_rise & swi_fall), 32'd0);
            if (swi_rise[2]) n_rise2++;
            if (swi_fall[0]) n_fall0++;
        end
    end

    task automatic do_reset(input logic [NB-1:0] v);
        @(negedge clk_2);
        SWI = v;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_2);
        reset_n = 1'b1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    initial begin
        // Reset with all switches high.
        SWI = 8'hFF;
        repeat (3) @(negedge clk_2);
        chk("rst_db", 32'(swi_db), 32'd0);
        chk("rst_rise", 32'(swi_rise), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_2);
        #1 chk("ff_e4_db", 32'(swi_db), 32'd0);
        @(posedge clk_2);
        #1 chk("ff_e5_db", 32'(swi_db), 32'hFF);
        chk("ff_e5_rise", 32'(swi_rise), 32'hFF);
        chk("ff_e5_any", 32'(any_rise), 32'd1);
        chk("ff_e5_pc", 32'(press_cnt), 32'd0);
        @(posedge clk_2);
        #1 chk("ff_e6_rise", 32'(swi_rise), 32'd0);
        chk("ff_e6_pc", 32'(press_cnt), 32'd1);

        // Single bit press latency.
        do_reset(8'h00);
        wait_neg(8);
        SWI = 8'h04;
        repeat (5) @(posedge clk_2);
        #1 chk("b2_e4_db", 32'(swi_db), 32'd0);
        @(posedge clk_2);
        #1 chk("b2_e5_db", 32'(swi_db), 32'h04);
        chk("b2_e5_rise", 32'(swi_rise), 32'h04);
        @(posedge clk_2);
        #1 chk("b2_e6_rise", 32'(swi_rise), 32'd0);
        chk("b2_e6_db", 32'(swi_db), 32'h04);

        // Glitch rejection on bit 2.
        @(negedge clk_2);
        SWI = 8'h00;
        wait_neg(12);
        n_rise2 = 0;
        for (int r = 0; r < 10; r++) begin
            SWI = 8'h04;
            wait_neg(3);
            SWI = 8'h00;
            wait_neg(2);
        end
        wait_neg(8);
        chk("glitch_db", 32'(swi_db), 32'd0);
        chk("glitch_rises", 32'(n_rise2), 32'd0);

        // 256 presses on bit 0 wrap the press counter.
        do_reset(8'h00);
        wait_neg(4);
        n_fall0 = 0;
        for (int p = 0; p < 256; p++) begin
            SWI = 8'h01;
            wait_neg(8);
            SWI = 8'h00;
            wait_neg(8);
        end
        wait_neg(10);
        chk("wrap_pc", 32'(press_cnt), 32'd0);
        chk("wrap_falls", 32'(n_fall0), 32'd256);

        // Asynchronous reset in the middle of a debounce run.
        do_reset(8'h01);
        wait_neg(10);
        SWI = 8'h03;
        repeat (5) @(posedge clk_2);
        #1 chk("mid_pre_db", 32'(swi_db), 32'h01);
        #1 reset_n = 1'b0;
        #1 chk("mid_async_db", 32'(swi_db), 32'd0);
        chk("mid_async_pc", 32'(press_cnt), 32'd0);
        chk("mid_async_rise", 32'(swi_rise), 32'd0);
        @(negedge clk_2);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_2);
        #1 chk("mid_e4_db", 32'(swi_db), 32'd0);
        @(posedge clk_2);
        #1 chk("mid_e5_rise", 32'(swi_rise), 32'h03);
        chk("mid_e5_db", 32'(swi_db), 32'h03);

        // Long hold on bit 0.
        do_reset(8'h01);
        repeat (66) @(posedge clk_2);
`ifdef SWI_AUTOREPEAT_EN
        #1 chk("hold_pc", 32'(press_cnt), 32'd4);
`else
        #1 chk("hold_pc", 32'(press_cnt), 32'd1);
`endif

        // Random sparse toggling, checked every cycle by the model.
        do_reset(8'h00);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_2);
            if ($urandom_range(0, 3) == 0) begin
                SWI = SWI ^ NB'($urandom & $urandom & $urandom);
            end
        end
        wait_neg(10);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/swi_conditioner.md
Name: swi_conditioner

Overview:
- Input-conditioning stage directly upstream of the top-level state machine and LCD/LED logic.
- Takes the raw SWI switch bank, synchronises it to clk_2, and debounces each bit independently.
- Emits debounced levels plus single-cycle rise/fall pulses, so downstream FSMs advance exactly once per switch action.
- Also keeps a wrapping count of debounced bit-0 rising edges for display on the LCD.

Parameters:
- NBITS, 8: number of switch bits conditioned.
- DEB_CYCLES, 4: consecutive mismatching cycles required before a bit's debounced level changes; legal range 1..255.
- REPEAT_CYCLES, 16: auto-repeat period in cycles; used only when SWI_AUTOREPEAT_EN is defined; legal range 2..65535.

Ports:
- clk_2  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- SWI  input  NBITS  raw asynchronous switch inputs.
- swi_db  output  NBITS  debounced switch levels.
- swi_rise  output  NBITS  one-cycle pulse per bit on debounced 0->1.
- swi_fall  output  NBITS  one-cycle pulse per bit on debounced 1->0.
- any_rise  output  1  OR-reduction of swi_rise, same cycle.
- press_cnt  output  8  count of swi_rise[0] pulses, wraps 255->0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - reset_n=0 immediately clears sync1, sync2, swi_db, swi_rise, swi_fall, any_rise, press_cnt and all per-bit counters.
  - Reset mid-debounce discards partial counts.
  - After release, first update on next clk_2 rising edge; swi_db starts at 0 regardless of SWI.
- Synchroniser: two flops per bit, SWI -> sync1 -> sync2. No logic between stages.
- Per-bit debounce (bit i, counter cnt[i], width sufficient for DEB_CYCLES):
  - sync2[i]==swi_db[i]: cnt[i]<=0.
  - sync2[i]!=swi_db[i] and cnt[i]<DEB_CYCLES-1: cnt[i]<=cnt[i]+1.
  - sync2[i]!=swi_db[i] and cnt[i]==DEB_CYCLES-1: swi_db[i]<=sync2[i], cnt[i]<=0, and the matching swi_rise[i] or swi_fall[i] is asserted for exactly this one cycle, registered and coincident with the swi_db change.
  - Any single matching cycle during a run resets the count (glitch rejection).
- Latency:
  - SWI[i] changes before edge 0 and is held: sync2 differs after edge 1; swi_db[i] and the pulse update at edge DEB_CYCLES+1.
  - DEB_CYCLES=4: update at edge 5.
  - DEB_CYCLES=1: update at edge 2.
- Pulses: swi_rise and swi_fall are registered, deasserted in every cycle without a transition, never both high for the same bit. Bits are fully independent; simultaneous transitions on several bits give simultaneous pulses.
- any_rise: registered, equals |swi_rise in the same cycle.
- press_cnt: increments by 1 in the cycle after each swi_rise[0] pulse is registered, i.e. press_cnt lags swi_rise[0] by one cycle. Wraps modulo 256, no saturation.
- Pure sequential block: no combinational path from SWI to any output.

Optional Feature:
- Macro: SWI_AUTOREPEAT_EN.
- Defined:
  - Each bit has a repeat counter rcnt[i], cleared whenever swi_db[i]==0 or on any swi_rise[i].
  - While swi_db[i]==1, rcnt[i] increments each cycle.
  - When rcnt[i] reaches REPEAT_CYCLES-1, swi_rise[i] pulses again for one cycle and rcnt[i]<=0.
  - Repeat pulses feed any_rise and press_cnt identically to real edges.
  - swi_fall is unaffected.
- Undefined: no repeat counters synthesised, REPEAT_CYCLES ignored, exactly one swi_rise per debounced 0->1.

Test Plan:
- Reset with SWI=8'hFF held -> swi_db=0, no pulses during reset; after release swi_db=8'hFF at edge 5, swi_rise=8'hFF for one cycle, any_rise=1, press_cnt=1 one cycle later.
- SWI[2] 0->1 held, DEB_CYCLES=4 -> swi_db[2]=1 and swi_rise[2]=1 at edge 5 only; swi_rise[2]=0 at edge 6; no other bits change.
- SWI[2] toggled high for 3 cycles then low, repeated 10 times -> swi_db[2] stays 0, zero pulses.
- Bit 0 debounced press/release 256 times -> press_cnt returns to 0 after wrap; one swi_fall[0] per release.
- reset_n pulsed low mid-run while cnt[1]=3 -> outputs clear asynchronously, before the next clk_2 edge; SWI[1] still high -> swi_rise[1] at edge 5 after release.
- SWI_AUTOREPEAT_EN defined, REPEAT_CYCLES=16, SWI[0] held high 60 cycles after debounce -> swi_rise[0] at debounce edge D, then D+16, D+32, D+48; press_cnt=4. Without macro -> a single pulse, press_cnt=1.
